// File: rtl/deser400_packet_decoder_if.sv
// rtl/deser400_packet_decoder_if.sv - symbol input and word output bundle for the deser400 packet decoder
interface deser400_packet_decoder_if;
    logic [4:0]  pdata;
    logic        error;
    logic        enable;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_sop;
    logic        dout_eop;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    modport master (
        output pdata, error, enable,
        input  dout, dout_valid, dout_sop, dout_eop, pkt_count, err_count
    );

    modport slave (
        input  pdata, error, enable,
        output dout, dout_valid, dout_sop, dout_eop, pkt_count, err_count
    );
endinterface

// File: rtl/deser400_packet_decoder.sv
// rtl/deser400_packet_decoder.sv - 4b/5b symbol decoder, J-K/T delimiter FSM and 16-bit word packer
module deser400_packet_decoder #(
    parameter int MAXLEN = 64
) (
    input  logic                        clk80,
    input  logic                        reset_n,
    deser400_packet_decoder_if.slave    bus
);
    localparam int WW = $clog2(MAXLEN + 1);

    typedef enum logic [2:0] {C_DATA, C_J, C_K, C_T, C_IDLE, C_INV} cls_t;
    typedef enum logic [1:0] {S_IDLE, S_GOT_J, S_DATA} state_t;

    cls_t           w_cls;
    logic [3:0]     w_nib;
    cls_t           r_cls;
    logic [3:0]     r_sym_nib;
    state_t         r_state;
    logic [15:0]    r_acc;
    logic [1:0]     r_nib;
    logic [WW-1:0]  r_wcnt;
    logic           r_err;
    logic           r_ovf;
    logic           r_sop_arm;
    logic [11:0]    w_partial;
    logic           w_close;
    logic           w_close_err;

    always_comb begin
        w_cls = C_INV;
        w_nib = 4'h0;
        if (!bus.error) begin
            case (bus.pdata)
                5'b11110: begin w_cls = C_DATA; w_nib = 4'h0; end
                5'b01001: begin w_cls = C_DATA; w_nib = 4'h1; end
                5'b10100: begin w_cls = C_DATA; w_nib = 4'h2; end
                5'b10101: begin w_cls = C_DATA; w_nib = 4'h3; end
                5'b01010: begin w_cls = C_DATA; w_nib = 4'h4; end
                5'b01011: begin w_cls = C_DATA; w_nib = 4'h5; end
                5'b01110: begin w_cls = C_DATA; w_nib = 4'h6; end
                5'b01111: begin w_cls = C_DATA; w_nib = 4'h7; end
                5'b10010: begin w_cls = C_DATA; w_nib = 4'h8; end
                5'b10011: begin w_cls = C_DATA; w_nib = 4'h9; end
                5'b10110: begin w_cls = C_DATA; w_nib = 4'hA; end
                5'b10111: begin w_cls = C_DATA; w_nib = 4'hB; end
                5'b11010: begin w_cls = C_DATA; w_nib = 4'hC; end
                5'b11011: begin w_cls = C_DATA; w_nib = 4'hD; end
                5'b11100: begin w_cls = C_DATA; w_nib = 4'hE; end
                5'b11101: begin w_cls = C_DATA; w_nib = 4'hF; end
                5'b11000: w_cls = C_J;
                5'b10001: w_cls = C_K;
                5'b01101: w_cls = C_T;
                5'b11111: w_cls = C_IDLE;
                default:  w_cls = C_INV;
            endcase
        end
    end

    // Leftover nibbles of an incomplete word, left-aligned in the 12-bit status field
    always_comb begin
        w_partial = 12'h000;
        case (r_nib)
            2'd1:    w_partial = {r_acc[3:0], 8'h00};
            2'd2:    w_partial = {r_acc[7:0], 4'h0};
            2'd3:    w_partial = r_acc[11:0];
            default: w_partial = 12'h000;
        endcase
    end

    assign w_close     = (r_state == S_DATA) &&
                         (!bus.enable || r_cls == C_T || r_cls == C_IDLE ||
                          r_cls == C_K || r_cls == C_J);
    assign w_close_err = r_err || !bus.enable || (r_cls != C_T);

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            r_cls          <= C_IDLE;
            r_sym_nib      <= 4'h0;
            r_state        <= S_IDLE;
            r_acc          <= 16'h0000;
            r_nib          <= 2'd0;
            r_wcnt         <= '0;
            r_err          <= 1'b0;
            r_ovf          <= 1'b0;
            r_sop_arm      <= 1'b0;
            bus.dout       <= 16'h0000;
            bus.dout_valid <= 1'b0;
            bus.dout_sop   <= 1'b0;
            bus.dout_eop   <= 1'b0;
            bus.pkt_count  <= 16'h0000;
            bus.err_count  <= 8'h00;
        end else begin
            r_cls          <= w_cls;
            r_sym_nib      <= w_nib;
            bus.dout_valid <= 1'b0;
            bus.dout_sop   <= 1'b0;
            bus.dout_eop   <= 1'b0;

            if (w_close) begin
                bus.dout       <= {w_close_err, r_ovf, r_nib, w_partial};
                bus.dout_valid <= 1'b1;
                bus.dout_sop   <= r_sop_arm;
                bus.dout_eop   <= 1'b1;
                bus.pkt_count  <= bus.pkt_count + 16'd1;
                if (w_close_err && bus.err_count != 8'hFF)
                    bus.err_count <= bus.err_count + 8'd1;
            end

            if (!bus.enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (r_cls == C_J) r_state <= S_GOT_J;
                    S_GOT_J: begin
                        if (r_cls == C_K) begin
                            r_state   <= S_DATA;
                            r_nib     <= 2'd0;
                            r_wcnt    <= '0;
                            r_err     <= 1'b0;
                            r_ovf     <= 1'b0;
                            r_sop_arm <= 1'b1;
                        end else if (r_cls != C_J) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        case (r_cls)
                            C_DATA: begin
                                if (r_wcnt == WW'(MAXLEN)) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_acc <= {r_acc[11:0], r_sym_nib};
                                    r_nib <= r_nib + 2'd1;
                                    if (r_nib == 2'd3) begin
                                        bus.dout       <= {r_acc[11:0], r_sym_nib};
                                        bus.dout_valid <= 1'b1;
                                        bus.dout_sop   <= r_sop_arm;
                                        r_sop_arm      <= 1'b0;
                                        r_wcnt         <= r_wcnt + WW'(1);
                                    end
                                end
                            end
                            C_INV:   r_err   <= 1'b1;
                            C_J:     r_state <= S_GOT_J;
                            default: r_state <= S_IDLE;
                        endcase
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_deser400_packet_decoder.sv
// tb/tb_deser400_packet_decoder.sv - directed bench for deser400_packet_decoder with MAXLEN=2
module tb_deser400_packet_decoder;
    logic clk80 = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;

    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        int          cyc;
    } rec_t;
    rec_t mon_q[$];

    localparam logic [4:0] SJ = 5'b11000;
    localparam logic [4:0] SK = 5'b10001;
    localparam logic [4:0] ST = 5'b01101;
    localparam logic [4:0] SI = 5'b11111;
    localparam logic [4:0] DT [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
    };

    deser400_packet_decoder_if bus ();

    deser400_packet_decoder #(.MAXLEN(2)) dut (
        .clk80   (clk80),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk80 = ~clk80;
    always @(posedge clk80) cyc <= cyc + 1;
    always @(negedge clk80)
        if (bus.dout_valid) mon_q.push_back('{bus.dout, bus.dout_sop, bus.dout_eop, cyc});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_word(input string tag, input logic [15:0] d, input logic s, input logic e,
                            output int at);
        rec_t r;
        at = -1;
        if (mon_q.size() == 0) begin
            nvec++;
            nbad++;
            $error("FAIL %s: observed no word expected %h", tag, d);
        end else begin
            r  = mon_q.pop_front();
            at = r.cyc;
            check(tag, {14'h0, r.d, r.sop, r.eop}, {14'h0, d, s, e});
        end
    endtask

    task automatic sym(input logic [4:0] s);
        @(negedge clk80);
        bus.pdata = s;
        bus.error = 1'b0;
    endtask

    task automatic sym_err(input logic [4:0] s);
        @(negedge clk80);
        bus.pdata = s;
        bus.error = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) sym(SI);
    endtask

    initial begin
        int c4;
        int at;
        reset_n    = 1'b0;
        bus.pdata  = SI;
        bus.error  = 1'b0;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk80);
        check("rst_dout", bus.dout, 16'h0000);
        check("rst_flags", {bus.dout_valid, bus.dout_sop, bus.dout_eop}, 3'b000);
        check("rst_pkt", bus.pkt_count, 16'd0);
        check("rst_err", bus.err_count, 8'd0);
        reset_n = 1'b1;
        idle(2);

        // 1: basic packet and two-cycle latency
        sym(SJ); sym(SK); sym(DT[1]); sym(DT[2]); sym(DT[3]);
        sym(DT[4]); c4 = cyc;
        sym(ST); idle(4);
        exp_word("t1_data", 16'h1234, 1'b1, 1'b0, at);
        check("t1_latency", at, c4 + 2);
        exp_word("t1_status", 16'h0000, 1'b0, 1'b1, at);
        check("t1_status_next", at, c4 + 3);
        check("t1_pkt", bus.pkt_count, 16'd1);
        check("t1_err", bus.err_count, 8'd0);

        // 2: partial nibble in status
        sym(SJ); sym(SK); sym(DT[10]); sym(DT[11]); sym(DT[12]); sym(DT[13]); sym(DT[14]);
        sym(ST); idle(4);
        exp_word("t2_data", 16'hABCD, 1'b1, 1'b0, at);
        exp_word("t2_status", 16'h1E00, 1'b0, 1'b1, at);
        check("t2_pkt", bus.pkt_count, 16'd2);

        // 3: invalid code, then error flag on a valid code
        sym(SJ); sym(SK); sym(DT[1]); sym(5'b00001); sym(DT[2]); sym(DT[3]); sym(DT[4]);
        sym(ST); idle(4);
        exp_word("t3_data", 16'h1234, 1'b1, 1'b0, at);
        exp_word("t3_status", 16'h8000, 1'b0, 1'b1, at);
        check("t3_err", bus.err_count, 8'd1);
        sym(SJ); sym(SK); sym(DT[1]); sym_err(DT[2]); sym(DT[2]); sym(DT[3]); sym(DT[4]);
        sym(ST); idle(4);
        exp_word("t3e_data", 16'h1234, 1'b1, 1'b0, at);
        exp_word("t3e_status", 16'h8000, 1'b0, 1'b1, at);
        check("t3e_err", bus.err_count, 8'd2);

        // 4: empty packet aborted by IDLE, then normal packet
        sym(SJ); sym(SK); idle(4);
        exp_word("t4_abort", 16'h8000, 1'b1, 1'b1, at);
        sym(SJ); sym(SK); sym(DT[5]); sym(DT[6]); sym(DT[7]); sym(DT[8]); sym(ST); idle(4);
        exp_word("t4_data", 16'h5678, 1'b1, 1'b0, at);
        exp_word("t4_status", 16'h0000, 1'b0, 1'b1, at);
        check("t4_pkt", bus.pkt_count, 16'd6);
        check("t4_err", bus.err_count, 8'd3);

        // 5: overflow at MAXLEN=2
        sym(SJ); sym(SK);
        for (int i = 0; i < 12; i++) sym(DT[i]);
        sym(ST); idle(4);
        exp_word("t5_w0", 16'h0123, 1'b1, 1'b0, at);
        exp_word("t5_w1", 16'h4567, 1'b0, 1'b0, at);
        exp_word("t5_status", 16'h4000, 1'b0, 1'b1, at);
        check("t5_err", bus.err_count, 8'd3);
        check("t5_pkt", bus.pkt_count, 16'd7);

        // J inside a packet closes it with err and restarts
        sym(SJ); sym(SK); sym(DT[1]); sym(DT[2]); sym(SJ); sym(SK); sym(DT[3]); sym(ST); idle(4);
        exp_word("rej_status", 16'hA120, 1'b1, 1'b1, at);
        exp_word("rej_second", 16'h1300, 1'b1, 1'b1, at);
        check("rej_err", bus.err_count, 8'd4);

        // enable low aborts DATA and suppresses further packets
        sym(SJ); sym(SK); sym(DT[7]); sym(DT[8]); sym(DT[9]);
        @(negedge clk80);
        bus.enable = 1'b0;
        bus.pdata  = SI;
        sym(SJ); sym(SK); sym(DT[1]); sym(DT[2]); sym(DT[3]); sym(DT[4]); sym(ST); idle(3);
        exp_word("en_abort", 16'hA780, 1'b1, 1'b1, at);
        check("en_quiet", mon_q.size(), 0);
        bus.enable = 1'b1;
        idle(3);
        check("en_pkt", bus.pkt_count, 16'd10);
        check("en_err", bus.err_count, 8'd5);

        // err_count saturation
        repeat (250) begin sym(SJ); sym(SK); sym(SI); end
        idle(4);
        check("sat_words", mon_q.size(), 250);
        check("sat_255", bus.err_count, 8'd255);
        mon_q.delete();
        sym(SJ); sym(SK); idle(4);
        check("sat_hold", bus.err_count, 8'd255);
        check("sat_pkt", bus.pkt_count, 16'd261);
        mon_q.delete();

        // 6: asynchronous reset mid-packet
        sym(SJ); sym(SK); sym(DT[1]); sym(DT[2]);
        @(negedge clk80);
        #1 reset_n = 1'b0;
        #1;
        check("t6_dout", bus.dout, 16'h0000);
        check("t6_pkt", bus.pkt_count, 16'd0);
        check("t6_err", bus.err_count, 8'd0);
        idle(2);
        reset_n = 1'b1;
        idle(4);
        check("t6_no_eop", mon_q.size(), 0);
        sym(SJ); sym(SK); sym(DT[9]); sym(DT[9]); sym(DT[9]); sym(DT[9]); sym(ST); idle(4);
        exp_word("t6_data", 16'h9999, 1'b1, 1'b0, at);
        exp_word("t6_status", 16'h0000, 1'b0, 1'b1, at);
        check("t6_pkt1", bus.pkt_count, 16'd1);
        check("t6_tail", mon_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
